// File: rtl/mont_pkg.sv
// Shared types and defaults for the Montgomery-core arbiter.
package mont_pkg;

    localparam int unsigned DefaultNReq = 2;
    localparam int unsigned DefaultW    = 255;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } mont_state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mont_rr_pick.sv
// Combinational winner selection: round-robin after last_owner_i by default,
// lowest-index fixed priority when MONT_ARB_FIXED_PRIO_EN is defined.
module mont_rr_pick
    import mont_pkg::*;
#(
    parameter int unsigned N_REQ = DefaultNReq,
    localparam int unsigned IdxW = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  last_owner_i,
    output logic [IdxW-1:0]  winner_o,
    output logic             valid_o
);

    logic [IdxW-1:0] idx;

`ifdef MONT_ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner_i;

    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = IdxW'(i);
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end
`else
    // Scan from the farthest offset back so the nearest requester after the
    // last owner is the last one written.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IdxW'((int'(last_owner_i) + k) % int'(N_REQ));
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end
`endif

endmodule

// File: rtl/mont_arbiter.sv
// Shares one Montgomery multiplier core among N_REQ requesters, one operation in
// flight. Define MONT_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mont_arbiter
    import mont_pkg::*;
#(
    parameter int unsigned N_REQ = DefaultNReq,
    parameter int unsigned W     = DefaultW
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0][W-1:0] i_a,
    input  logic [N_REQ-1:0][W-1:0] i_b,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ-1:0]        o_done,
    output logic [W-1:0]            o_result,
    output logic                    o_busy,
    output logic                    o_mm_start,
    output logic [W-1:0]            o_mm_a,
    output logic [W-1:0]            o_mm_b,
    input  logic [W-1:0]            i_mm_result,
    input  logic                    i_mm_finished
);

    localparam int unsigned IdxW = idx_width(N_REQ);

    mont_state_e      state_q;
    logic [IdxW-1:0]  last_owner_q;
    logic [IdxW-1:0]  owner_q;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [W-1:0]     result_q;
    logic             busy_q;
    logic             start_q;
    logic [W-1:0]     mm_a_q, mm_b_q;

    mont_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i        (i_req),
        .last_owner_i (last_owner_q),
        .winner_o     (pick_idx),
        .valid_o      (pick_valid)
    );

    always_comb begin
        grant_d           = '0;
        grant_d[pick_idx] = 1'b1;
        done_d            = '0;
        done_d[owner_q]   = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= IdxW'(N_REQ - 1);
            owner_q      <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            mm_a_q       <= '0;
            mm_b_q       <= '0;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_q      <= S_BUSY;
                        owner_q      <= pick_idx;
                        last_owner_q <= pick_idx;
                        mm_a_q       <= i_a[pick_idx];
                        mm_b_q       <= i_b[pick_idx];
                        grant_q      <= grant_d;
                        start_q      <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (i_mm_finished) begin
                        state_q  <= S_IDLE;
                        result_q <= i_mm_result;
                        done_q   <= done_d;
                        busy_q   <= 1'b0;
                        mm_a_q   <= '0;
                        mm_b_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_grant    = grant_q;
    assign o_done     = done_q;
    assign o_result   = result_q;
    assign o_busy     = busy_q;
    assign o_mm_start = start_q;
    assign o_mm_a     = mm_a_q;
    assign o_mm_b     = mm_b_q;

endmodule

// File: doc/mont_arbiter.md
MONT_ARBITER -- requirements
Module: mont_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, which sets the number of requesters (2..8).
REQ-002 SHALL have parameter W, default 255, which sets the operand and result width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have these ports, in this order:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_req  in  N_REQ  per-requester request level
- i_a  in  N_REQ x W  per-requester operand A
- i_b  in  N_REQ x W  per-requester operand B
- o_grant  out  N_REQ  one-hot grant pulse
- o_done  out  N_REQ  one-hot completion pulse
- o_result  out  W  result of the last completed operation
- o_busy  out  1  high while an operation is outstanding
- o_mm_start  out  1  Montgomery core start pulse
- o_mm_a  out  W  core operand A
- o_mm_b  out  W  core operand B
- i_mm_result  in  W  core product
- i_mm_finished  in  1  core completion pulse

Function
REQ-005 SHALL share one Montgomery multiplier core among N_REQ requesters, with at most one operation in flight.
REQ-006 SHALL implement FSM states S_IDLE and S_BUSY.
REQ-007 SHALL, in S_IDLE with any i_req high:
- select a winner;
- register its i_a, i_b and index;
- go to S_BUSY.
REQ-008 SHALL, in the cycle after the selection, drive o_grant[winner]=1 and o_mm_start=1 for exactly one cycle (registered).
REQ-009 SHALL hold o_mm_a and o_mm_b stable from the registered operands for the whole S_BUSY period, and drive them to 0 in S_IDLE.
REQ-010 SHALL, in S_BUSY on i_mm_finished:
- capture i_mm_result into o_result;
- pulse o_done[owner] for one cycle on the next edge;
- return to S_IDLE.
REQ-011 SHALL hold o_result until the next completion.
REQ-012 SHALL sample i_req only in S_IDLE.
REQ-013 Requesters SHALL deassert i_req before the o_done cycle unless issuing a new operation; a level still high in S_IDLE is a new request.
REQ-014 SHALL, by default, select round-robin: scan starts at (last_owner+1) mod N_REQ, and last_owner updates at each grant.
REQ-015 SHALL allow a new selection in the same cycle o_done is pulsed (back-to-back operations), giving 1 idle core cycle between operations.
REQ-016 SHALL ignore i_mm_finished in S_IDLE.
REQ-017 SHALL ignore i_req changes during S_BUSY.
REQ-018 SHALL drive o_busy=1 from the o_grant cycle through the cycle that samples i_mm_finished.
REQ-019 SHALL keep o_grant and o_done one-hot or zero at all times.

Reset
REQ-020 SHALL, on i_rst assertion, immediately (asynchronously) force:
- state to S_IDLE;
- last_owner to N_REQ-1, so requester 0 has first priority;
- all outputs and registers to 0.
REQ-021 SHALL, on reset mid-operation, abandon the operation without a done pulse; the core is reset by the same i_rst.

Configuration
REQ-022 SHALL, when MONT_ARB_FIXED_PRIO_EN is defined, use fixed priority (the lowest index with i_req high wins, and last_owner is unused).
REQ-023 SHALL, without MONT_ARB_FIXED_PRIO_EN, use the round-robin selection of REQ-014.

Structure
REQ-024 SHALL place the state enum, the default W (255) and the default N_REQ in the shared package mont_pkg.
REQ-025 SHALL implement the combinational winner selection as one sub-module, mont_rr_pick (inputs req and last_owner; outputs winner index and valid).

Verification
REQ-026 Bench SHALL use a core stub with fixed 5-cycle latency returning a*b mod 17 (truncated), and cover these scenarios:
- Single request: req[0] with a=3, b=4 -> grant[0] 1 cycle later; o_mm_start coincident; done[0] with o_result=12; o_busy low afterwards.
- Simultaneous requests, round-robin: req[0] and req[1] held continuously -> grant order 0,1,0,1; each done precedes the next grant; 1 idle core cycle between operations.
- Simultaneous requests, MONT_ARB_FIXED_PRIO_EN defined: req[0] and req[1] held continuously -> requester 0 always granted; requester 1 never granted.
- Reset mid-operation: i_rst 2 cycles after grant[1] -> all outputs 0 immediately, no done pulse; after release, req[1] and req[0] together -> grant[0] first.
- Spurious and late inputs: i_mm_finished pulsed in S_IDLE -> no done and o_result unchanged; operands changed during S_BUSY -> o_mm_a and o_mm_b unchanged.
- Back-to-back from one requester: req[1] held high after done[1] -> new grant[1] in the cycle after done[1], with the new operands captured.
